// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared types and constants for the register-file writeback arbiter
//
// Purpose : register address type, FSM state and requester encodings, grant
//           vector bit positions and the zero-sweep index helper.
// Ports   : none (package).

package rf_arb_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   // Bit positions inside the one-hot grant vector.
   localparam int GNT_ALU = 0;
   localparam int GNT_LSU = 1;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   typedef enum logic {ST_INIT, ST_RUN}  arb_state_e;
   typedef enum logic {REQ_ALU, REQ_LSU} req_e;

   // Sweep index successor. After the last register the index wraps to x0,
   // which the FSM uses as its "sweep finished" marker since x0 is never swept.
   function automatic reg_addr_t next_sweep_idx(input reg_addr_t idx);
      return (idx == reg_addr_t'(NUM_REGS - 1)) ? '0 : idx + reg_addr_t'(1);
   endfunction

endpackage

// File: rtl/rf_wb_grant.sv
// rtl/rf_wb_grant.sv - ALU/LSU writeback grant logic with starvation or round-robin state
//
// Purpose : decides which writeback requester owns the register-file write
//           port this cycle. Grants are combinational from the valids and the
//           arbitration state; only requesters with valid high can be granted.
//           Build option: RF_ARB_ROUND_ROBIN_EN selects round-robin arbitration
//           (rr_ptr); otherwise fixed ALU priority with an LSU starvation
//           counter (wait_cnt) bounded by MAX_WAIT.
// Ports   : clk        in   clock, rising edge
//           rst_n      in   asynchronous active-low reset
//           run        in   arbiter in RUN state; no grant is issued otherwise
//           alu_valid  in   ALU writeback request
//           lsu_valid  in   LSU writeback request
//           grant      out  one-hot grant, bit GNT_ALU / GNT_LSU

import rf_arb_pkg::*;

module rf_wb_grant #(
   parameter int MAX_WAIT = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic       alu_valid,
   input  logic       lsu_valid,
   output logic [1:0] grant
);

`ifdef RF_ARB_ROUND_ROBIN_EN

   req_e rr_ptr;

   // On conflict the requester that did not win last time is served;
   // a lone requester always wins.
   always_comb begin
      grant = '0;
      if (run) begin
         if (alu_valid && lsu_valid) begin
            if (rr_ptr == REQ_ALU) grant[GNT_LSU] = 1'b1;
            else                   grant[GNT_ALU] = 1'b1;
         end else if (alu_valid) begin
            grant[GNT_ALU] = 1'b1;
         end else if (lsu_valid) begin
            grant[GNT_LSU] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= REQ_ALU;
      end else if (grant[GNT_ALU]) begin
         rr_ptr <= REQ_ALU;
      end else if (grant[GNT_LSU]) begin
         rr_ptr <= REQ_LSU;
      end
   end

`else

   localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

   logic [WAIT_W-1:0] wait_cnt;
   logic              lsu_urgent;

   // Once the LSU has been refused MAX_WAIT cycles in a row it overrides the ALU.
   assign lsu_urgent = (wait_cnt == WAIT_W'(MAX_WAIT));

   always_comb begin
      grant = '0;
      if (run) begin
         if (lsu_valid && (!alu_valid || lsu_urgent)) grant[GNT_LSU] = 1'b1;
         else if (alu_valid)                          grant[GNT_ALU] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (!run || !lsu_valid || grant[GNT_LSU]) begin
         wait_cnt <= '0;
      end else if (!lsu_urgent) begin
         wait_cnt <= wait_cnt + WAIT_W'(1);
      end
   end

`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-port owner: zero sweep then ALU/LSU writeback arbitration
//
// Purpose : after reset writes zero to x1..x31 (one register per cycle), then
//           shares the single write port between ALU and LSU writeback using
//           valid/ready handshakes. Register-file outputs are registered, so a
//           transfer accepted in cycle N appears on rf_* after the next edge.
//           Writes to x0 are accepted but never reach the register file.
//           Build option: RF_ARB_ROUND_ROBIN_EN (see rf_wb_grant).
// Ports   : clk           in   clock, rising edge
//           rst_n         in   asynchronous active-low reset
//           alu_valid/rd/data  in   ALU writeback request
//           alu_ready     out  ALU request accepted this cycle
//           lsu_valid/rd/data  in   LSU writeback request
//           lsu_ready     out  LSU request accepted this cycle
//           rf_en/rd/data out  register-file write port (registered)
//           init_done     out  zero sweep complete (registered)
//           conflict_cnt  out  saturating count of RUN cycles with both valids high

import rf_arb_pkg::*;

module regfile_wb_arbiter #(
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4,
   parameter int CNT_W    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  alu_valid,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [DATA_W-1:0]     alu_data,
   output logic                  alu_ready,
   input  logic                  lsu_valid,
   input  logic [REG_ADDR_W-1:0] lsu_rd,
   input  logic [DATA_W-1:0]     lsu_data,
   output logic                  lsu_ready,
   output logic                  rf_en,
   output logic [REG_ADDR_W-1:0] rf_rd,
   output logic [DATA_W-1:0]     rf_data,
   output logic                  init_done,
   output logic [CNT_W-1:0]      conflict_cnt
);

   arb_state_e state;
   reg_addr_t  sweep_idx;
   logic [1:0] grant;

   rf_wb_grant #(
      .MAX_WAIT (MAX_WAIT)
   ) u_grant (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (state == ST_RUN),
      .alu_valid (alu_valid),
      .lsu_valid (lsu_valid),
      .grant     (grant)
   );

   assign alu_ready = grant[GNT_ALU];
   assign lsu_ready = grant[GNT_LSU];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_INIT;
         sweep_idx    <= reg_addr_t'(1);
         rf_en        <= 1'b0;
         rf_rd        <= '0;
         rf_data      <= '0;
         init_done    <= 1'b0;
         conflict_cnt <= '0;
      end else begin
         case (state)
            ST_INIT: begin
               // sweep_idx == 0 only after x31 has been written (index wrapped).
               if (sweep_idx == '0) begin
                  rf_en     <= 1'b0;
                  init_done <= 1'b1;
                  state     <= ST_RUN;
               end else begin
                  rf_en     <= 1'b1;
                  rf_rd     <= sweep_idx;
                  rf_data   <= '0;
                  sweep_idx <= next_sweep_idx(sweep_idx);
               end
            end

            ST_RUN: begin
               if (grant[GNT_ALU]) begin
                  rf_en   <= (alu_rd != '0);
                  rf_rd   <= alu_rd;
                  rf_data <= alu_data;
               end else if (grant[GNT_LSU]) begin
                  rf_en   <= (lsu_rd != '0);
                  rf_rd   <= lsu_rd;
                  rf_data <= lsu_data;
               end else begin
                  rf_en   <= 1'b0;
               end

               if (alu_valid && lsu_valid && (conflict_cnt != '1)) begin
                  conflict_cnt <= conflict_cnt + CNT_W'(1);
               end
            end

            default: begin
               state <= ST_INIT;
            end
         endcase
      end
   end

endmodule
